// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
// Module   : vga_capture
// Purpose  : Samples a VGA sync/RGB stream, recovers pixel coordinates, checks
//            sync timing against the nominal raster and reports frame stats.
// Revision : 1.0
// ============================================================================
module vga_capture #(
   parameter int H_DISPLAY    = 640,
   parameter int H_SYNC_START = 656,
   parameter int H_TOTAL      = 800,
   parameter int V_DISPLAY    = 480,
   parameter int V_SYNC_START = 490,
   parameter int V_TOTAL      = 525
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic [1:0]  i_red,
   input  logic [1:0]  i_green,
   input  logic [1:0]  i_blue,
   output logic [9:0]  o_hpos,
   output logic [9:0]  o_vpos,
   output logic [5:0]  o_pixel,
   output logic        o_pixel_valid,
   output logic        o_locked,
   output logic        o_frame_start,
   output logic        o_sync_err,
   output logic [7:0]  o_err_count,
   output logic [18:0] o_lit_count
);

   localparam logic [9:0] c_H_DISP   = 10'(H_DISPLAY);
   localparam logic [9:0] c_H_SYNC   = 10'(H_SYNC_START);
   localparam logic [9:0] c_H_SYNC_1 = 10'(H_SYNC_START + 1);
   localparam logic [9:0] c_H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] c_V_DISP   = 10'(V_DISPLAY);
   localparam logic [9:0] c_V_SYNC   = 10'(V_SYNC_START);
   localparam logic [9:0] c_V_LAST   = 10'(V_TOTAL - 1);

   localparam logic [1:0] c_SEARCH = 2'd0;
   localparam logic [1:0] c_LINE   = 2'd1;
   localparam logic [1:0] c_LOCKED = 2'd2;

   // s1 sample and s2 (previous s1 sync) registers
   logic        r_hs1;
   logic        r_vs1;
   logic        r_hs2;
   logic        r_vs2;
   logic [5:0]  r_pix;

   // h/v counters always describe the s1 sample
   logic [9:0]  r_h;
   logic [9:0]  r_v;
   logic [1:0]  r_state;
   logic [7:0]  r_err;
   logic [18:0] r_acc;
   logic        r_acc_ok;
   logic [18:0] r_lit;

   logic        w_hedge;
   logic        w_vedge;
   logic        w_locked;
   logic        w_at_hs;
   logic        w_at_vs;
   logic        w_viol;
   logic        w_valid;
   logic        w_fstart;
   logic        w_lit;
   logic [9:0]  w_h_next;
   logic [9:0]  w_v_next;
   logic [1:0]  w_state_next;

   assign w_hedge  = ~r_hs1 & r_hs2;
   assign w_vedge  = ~r_vs1 & r_vs2;
   assign w_locked = (r_state == c_LOCKED);
   assign w_at_hs  = (r_h == c_H_SYNC);
   assign w_at_vs  = (r_h == 10'd0) && (r_v == c_V_SYNC);

   // Any missing or misplaced sync edge is one violation, however many terms fire
   assign w_viol = w_locked & ((w_hedge & ~w_at_hs) |
                               (w_vedge & ~w_at_vs) |
                               (w_at_hs & ~w_hedge) |
                               (w_at_vs & ~w_vedge));

   assign w_valid  = w_locked && (r_h < c_H_DISP) && (r_v < c_V_DISP);
   assign w_fstart = w_locked && (r_h == 10'd0) && (r_v == 10'd0);
   assign w_lit    = w_valid && (r_pix != 6'd0);

   always_comb begin
      w_h_next = r_h + 10'd1;
      w_v_next = r_v;
      if (r_h == c_H_LAST) begin
         w_h_next = 10'd0;
         w_v_next = (r_v == c_V_LAST) ? 10'd0 : r_v + 10'd1;
      end
      // Sync edges re-anchor the counters in every state; vsync also fixes the line
      if (w_vedge) begin
         w_h_next = 10'd1;
         w_v_next = c_V_SYNC;
      end else if (w_hedge) begin
         w_h_next = c_H_SYNC_1;
         w_v_next = r_v;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_SEARCH: if (w_hedge) w_state_next = c_LINE;
         c_LINE:   if (w_vedge) w_state_next = c_LOCKED;
         c_LOCKED: if (w_viol)  w_state_next = c_LINE;
         default:  w_state_next = c_SEARCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hs1   <= 1'b0;
         r_vs1   <= 1'b0;
         r_hs2   <= 1'b0;
         r_vs2   <= 1'b0;
         r_pix   <= 6'd0;
         r_h     <= 10'd0;
         r_v     <= 10'd0;
         r_state <= c_SEARCH;
      end else begin
         r_hs1   <= i_hsync;
         r_vs1   <= i_vsync;
         r_hs2   <= r_hs1;
         r_vs2   <= r_vs1;
         r_pix   <= {i_red, i_green, i_blue};
         r_h     <= w_h_next;
         r_v     <= w_v_next;
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 8'd0;
      end else if (w_viol && (r_err != 8'hFF)) begin
         r_err <= r_err + 8'd1;
      end
   end

   // Lit accumulator: a frame is published only if it was seen whole while locked
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= 19'd0;
         r_acc_ok <= 1'b0;
         r_lit    <= 19'd0;
      end else begin
         if (w_fstart) begin
            if (r_acc_ok) begin
               r_lit <= r_acc;
            end
            r_acc    <= {18'd0, w_lit};
            r_acc_ok <= 1'b1;
         end else if (w_lit) begin
            r_acc <= r_acc + 19'd1;
         end
         if (!w_locked || w_viol) begin
            r_acc_ok <= 1'b0;
         end
      end
   end

   assign o_hpos        = r_h;
   assign o_vpos        = r_v;
   assign o_pixel       = r_pix;
   assign o_pixel_valid = w_valid;
   assign o_locked      = w_locked;
   assign o_frame_start = w_fstart;
   assign o_sync_err    = w_viol;
   assign o_err_count   = r_err;
   assign o_lit_count   = r_lit;

endmodule
`default_nettype wire

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of the VGA pixel generator: samples the 640x480 hsync/vsync/RGB stream, recovers pixel coordinates, checks sync timing against the nominal 640x480@60 raster, and reports per-pixel data plus per-frame statistics. It sits in the verification/debug path, either on the FPGA loopback build or on-chip behind a debug mux. It lets the team self-check rendered frames and sync integrity without an external monitor.

## Interface

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_SYNC_START, 656, coordinate of the first hsync-asserted pixel
- H_TOTAL, 800, clocks per line
- V_DISPLAY, 480, visible lines
- V_SYNC_START, 490, line on which vsync asserts
- V_TOTAL, 525, lines per frame

Ports:
- clk  in  1  pixel clock; same clock as the generator
- rst_n  in  1  asynchronous active-low reset
- i_hsync  in  1  horizontal sync, active-low
- i_vsync  in  1  vertical sync, active-low
- i_red, i_green, i_blue  in  2 each  pixel colour
- o_hpos  out  10  recovered x of the current output sample
- o_vpos  out  10  recovered y of the current output sample
- o_pixel  out  6  registered {red, green, blue} of the current sample
- o_pixel_valid  out  1  o_locked and o_hpos < H_DISPLAY and o_vpos < V_DISPLAY
- o_locked  out  1  high in LOCKED
- o_frame_start  out  1  one-cycle pulse when the output sample is (0,0) while locked
- o_sync_err  out  1  one-cycle pulse on a detected timing violation
- o_err_count  out  8  saturating violation count, cleared only by reset
- o_lit_count  out  19  non-black visible pixels in the last complete locked frame

## Operation

- Stage s1 registers all inputs. Stage s2 holds the previous s1 sync values for edge detection. All outputs describe the s1 sample.
- h_cnt (10b) increments every clock and wraps H_TOTAL-1 to 0. v_cnt (10b) increments when h_cnt wraps and itself wraps V_TOTAL-1 to 0.
- Hsync leading edge: s1 hsync is 0 and s2 hsync is 1. On that cycle the s1 sample is at x = H_SYNC_START; the next h_cnt is forced to H_SYNC_START+1.
- Vsync leading edge: on that cycle the s1 sample is at (0, V_SYNC_START); the next value is forced to h=1, v=V_SYNC_START.
- Forcing happens in every state. In LOCKED, forcing onto the already-predicted value is a no-op.
- FSM states:
  - SEARCH: reset state. Moves to LINE on the first hsync edge.
  - LINE: moves to LOCKED on the first vsync edge.
  - LOCKED: normal operation.
- A violation is recognised only in LOCKED. Any of these is a violation:
  - hsync edge while h_cnt != H_SYNC_START
  - vsync edge while (h_cnt, v_cnt) != (0, V_SYNC_START)
  - h_cnt == H_SYNC_START with no hsync edge
  - (h_cnt, v_cnt) == (0, V_SYNC_START) with no vsync edge
- On a violation: o_sync_err pulses, o_err_count increments (saturates at 255), the state goes to LINE, and the lit accumulator is invalidated. Simultaneous violations count once.
- Lit accumulator (19b): adds 1 for each o_pixel_valid sample with o_pixel != 0.
- At o_frame_start: if the accumulator is valid, it is copied to o_lit_count. The accumulator is then cleared and marked valid; the (0,0) pixel itself counts toward the new frame.
- The first frame after entering LOCKED is partial. Its accumulator starts invalid, so the first o_lit_count update occurs at the second o_frame_start.

## Timing

- Reset (async assert, sync deassert expected upstream) forces all outputs and internal state to 0 and the state to SEARCH.
- Input to output latency is one clock. o_hpos/o_vpos/o_pixel refer to the input sampled on the previous edge.
- o_locked rises in the clock after the s1 sample that carries the first vsync edge seen in LINE.
- o_frame_start and o_sync_err are single-cycle pulses, never held.
- o_lit_count changes only in the cycle o_frame_start is high.
- Maximum count is 307200, which fits 19 bits; no overflow handling is needed.
- Reset mid-frame: immediate return to SEARCH with o_err_count = 0. Relock needs one hsync and one vsync edge.

## Test plan

- Reset, then drive the ideal 640x480 stream with all-black pixels -> o_locked after the first vsync edge; o_sync_err never pulses; o_lit_count = 0 after the second o_frame_start.
- Drive a white 10x10 square at (100,50) -> o_pixel = 6'h3F exactly while o_hpos 100..109 and o_vpos 50..59; o_lit_count = 100 each frame.
- Delay one hsync leading edge by one clock in a locked frame -> exactly one o_sync_err, o_err_count = 1, o_locked low until the next vsync edge, o_lit_count not updated for the disturbed frame.
- Suppress one vsync pulse -> o_sync_err pulses at the expected (0,490) point; relock at the following frame's vsync.
- Assert rst_n low mid-frame for 3 clocks -> all outputs read 0 during reset; relock and correct coordinates are restored within one frame plus one line.
- Inject 300 hsync errors -> o_err_count saturates at 255.
